// File: rtl/maze_map_loader.sv
// rtl/maze_map_loader.sv - streams map rows from a 1-cycle-latency ROM into a row file and answers cell queries.
// Optional checksum accumulator is built only when MAP_CHECKSUM_EN is defined.
module maze_map_loader #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int ADDR_W  = 3,
    parameter int COORD_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLS-1:0]    rom_data,
    output logic               map_valid,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [COORD_W-1:0] q_x,
    input  logic [ADDR_W-1:0]  q_y,
    output logic               r_valid,
    output logic               r_open,
    output logic [COLS-1:0]    checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);

    state_t             state;
    state_t             state_next;
    logic               en_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [COLS-1:0]    rows [ROWS];
    logic [COLS-1:0]    sel_row;
    logic               cell_open;
    logic               accept;
    logic               fetch_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = FETCH;
            FETCH:   if (rom_addr == LAST_ADDR) state_next = DRAIN;
            DRAIN:   if (en_d && addr_d == LAST_ADDR) state_next = READY;
            READY:   if (load) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    assign rom_en      = (state == FETCH);
    assign map_valid   = (state == READY);
    assign q_ready     = (state == READY);
    assign accept      = q_valid && q_ready;
    assign fetch_start = (state_next == FETCH) && (state != FETCH);

    // The address counter wraps to zero on the last row so the next fetch starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
        end else if (state == FETCH) begin
            rom_addr <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + 1'b1;
        end
    end

    // Delayed enable/address line up with the ROM's registered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d   <= 1'b0;
            addr_d <= '0;
        end else begin
            en_d   <= rom_en;
            addr_d <= rom_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                rows[i] <= '0;
            end
        end else if (en_d) begin
            for (int i = 0; i < ROWS; i++) begin
                if (addr_d == i[ADDR_W-1:0]) begin
                    rows[i] <= rom_data;
                end
            end
        end
    end

    // Out-of-range coordinates match no entry and therefore read as closed.
    always_comb begin
        sel_row   = '0;
        cell_open = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (q_y == i[ADDR_W-1:0]) begin
                sel_row = rows[i];
            end
        end
        for (int j = 0; j < COLS; j++) begin
            if (q_x == j[COORD_W-1:0]) begin
                cell_open = sel_row[COLS-1-j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_open  <= 1'b0;
        end else begin
            r_valid <= accept;
            if (accept) begin
                r_open <= cell_open;
            end
        end
    end

`ifdef MAP_CHECKSUM_EN
    logic [COLS-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (fetch_start) begin
            checksum_q <= '0;
        end else if (en_d) begin
            checksum_q <= checksum_q ^ rom_data;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_fetch_start;

    assign unused_fetch_start = fetch_start;
    assign checksum           = '0;
`endif

endmodule

// File: tb/tb_maze_map_loader.sv
// tb/tb_maze_map_loader.sv - self-checking bench for maze_map_loader with a local ROM model and response scoreboard.
module tb_maze_map_loader;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int ADDR_W  = 3;
    localparam int COORD_W = 3;

    logic               clk;
    logic               rst_n;
    logic               load;
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLS-1:0]    rom_data;
    logic               map_valid;
    logic               q_valid;
    logic               q_ready;
    logic [COORD_W-1:0] q_x;
    logic [ADDR_W-1:0]  q_y;
    logic               r_valid;
    logic               r_open;
    logic [COLS-1:0]    checksum;

    int checks;
    int errors;
    int cyc;
    int resp_count;
    logic last_open;

    typedef struct {
        int   cyc;
        logic open;
    } exp_t;

    exp_t exp_q[$];
    logic [COLS-1:0] rom_mem [ROWS];

    maze_map_loader #(
        .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .map_valid(map_valid),
        .q_valid(q_valid), .q_ready(q_ready), .q_x(q_x), .q_y(q_y),
        .r_valid(r_valid), .r_open(r_open), .checksum(checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rom_mem[0] = 8'h01; rom_mem[1] = 8'h80; rom_mem[2] = 8'hF5; rom_mem[3] = 8'h3C;
        rom_mem[4] = 8'h3C; rom_mem[5] = 8'h5A; rom_mem[6] = 8'h5A; rom_mem[7] = 8'h04;
    end

    // ROM model: registered read, one cycle latency
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic model_open(int x, int y);
        logic [COLS-1:0] r;
        if (y >= ROWS || x >= COLS) return 1'b0;
        r = rom_mem[y];
        return r[COLS-1-x];
    endfunction

    // Response monitor: pop/compare first, then record any acceptance for next cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_open = 1'b0;
        end else begin
            if (r_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_response cyc=%0d r_open=%b", cyc, r_open);
                end else begin
                    e = exp_q.pop_front();
                    resp_count++;
                    if (r_open !== e.open || cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL response got open=%b cyc=%0d expected open=%b cyc=%0d",
                                 r_open, cyc, e.open, e.cyc);
                    end
                end
            end else if (r_open !== last_open) begin
                checks++;
                errors++;
                $display("FAIL r_open_hold got %b expected %b", r_open, last_open);
            end
            if (q_valid && q_ready) begin
                e.cyc  = cyc + 1;
                e.open = model_open(int'(q_x), int'(q_y));
                exp_q.push_back(e);
            end
            last_open = r_open;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; q_valid = 1'b0; q_x = '0; q_y = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({rom_en, map_valid, q_ready, r_valid, r_open} !== 5'b0 || rom_addr !== '0 || checksum !== '0) begin
                errors++;
                $display("FAIL reset_idle got en=%b addr=%0d mv=%b qr=%b rv=%b ro=%b cs=%h expected all 0",
                         rom_en, rom_addr, map_valid, q_ready, r_valid, r_open, checksum);
            end
        end
    endtask

    task automatic test_load();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (rom_en !== (k <= 8) || (k <= 8 && rom_addr !== ADDR_W'(k - 1)) || map_valid !== (k >= 10)) begin
                errors++;
                $display("FAIL load_seq cycle=%0d got en=%b addr=%0d mv=%b expected en=%b addr=%0d mv=%b",
                         k, rom_en, rom_addr, map_valid, (k <= 8), k - 1, (k >= 10));
            end
        end
    endtask

    task automatic test_queries();
        int xs[6] = '{0, 7, 0, 7, 5, 2};
        int ys[6] = '{0, 0, 1, 1, 7, 2};
        logic req[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int base = resp_count;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (model_open(xs[i], ys[i]) !== req[i]) begin
                errors++;
                $display("FAIL rom_model x=%0d y=%0d got %b expected %b", xs[i], ys[i], model_open(xs[i], ys[i]), req[i]);
            end
            @(posedge clk); #1 q_valid = 1'b1; q_x = COORD_W'(xs[i]); q_y = ADDR_W'(ys[i]);
            @(posedge clk); #1 q_valid = 1'b0;
            repeat (2) @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (resp_count - base !== 6 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL single_queries got %0d responses pending=%0d expected 6 pending=0", resp_count - base, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int base = resp_count;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 q_valid = 1'b1; q_x = COORD_W'(7 - i); q_y = ADDR_W'(i + 1);
            @(posedge clk);
        end
        #1 q_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp_count - base !== 4 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL back_to_back got %0d responses pending=%0d expected 4 pending=0", resp_count - base, exp_q.size());
        end
    endtask

    task automatic test_reload_with_query();
        int base = resp_count;
        @(posedge clk); #1 load = 1'b1; q_valid = 1'b1; q_x = 3'd7; q_y = 3'd0;
        @(posedge clk); #1 load = 1'b0; q_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (map_valid !== (k >= 10)) begin
                errors++;
                $display("FAIL reload_map_valid cycle=%0d got %b expected %b", k, map_valid, (k >= 10));
            end
        end
        checks++;
        if (resp_count - base !== 1) begin
            errors++;
            $display("FAIL reload_query got %0d responses expected 1", resp_count - base);
        end
    endtask

    task automatic test_checksum();
        logic [COLS-1:0] x;
        logic [COLS-1:0] want;
        x = '0;
        for (int i = 0; i < ROWS; i++) x = x ^ rom_mem[i];
`ifdef MAP_CHECKSUM_EN
        want = x;
`else
        want = '0;
`endif
        @(negedge clk);
        checks++;
        if (checksum !== want || x !== 8'h70) begin
            errors++;
            $display("FAIL checksum got %h (model %h) expected %h", checksum, x, want);
        end
    endtask

    task automatic test_reset_mid_fetch();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_en, map_valid, q_ready, r_valid, r_open} !== 5'b0 || rom_addr !== '0 || checksum !== '0) begin
            errors++;
            $display("FAIL reset_mid_fetch got en=%b addr=%0d mv=%b qr=%b rv=%b ro=%b cs=%h expected all 0",
                     rom_en, rom_addr, map_valid, q_ready, r_valid, r_open, checksum);
        end
        @(posedge clk); #1 rst_n = 1'b1; q_valid = 1'b1; q_x = 3'd0; q_y = 3'd1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (map_valid !== 1'b0 || rom_en !== 1'b0 || q_ready !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle cycle=%0d got mv=%b en=%b qr=%b expected 0 0 0", k, map_valid, rom_en, q_ready);
            end
        end
        @(posedge clk); #1 q_valid = 1'b0; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (map_valid !== 1'b1) begin
            errors++;
            $display("FAIL reload_after_reset got mv=%b expected 1", map_valid);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; resp_count = 0; last_open = 1'b0;
        test_reset();
        test_load();
        test_queries();
        test_back_to_back();
        test_checksum();
        test_reload_with_query();
        test_checksum();
        test_reset_mid_fetch();
        test_checksum();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
